sub_chain_ctrl: RTL and testbench

SUB_CHAIN_CTRL -- requirements
Module: sub_chain_ctrl

---
 rtl/sub_chain_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sub_chain_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : Full_Subtractor / sub_chain_ctrl
// Description : Full_Subtractor is an N-bit subtractor slice with borrow in
//               and borrow out.
//               sub_chain_ctrl computes a W-bit (W = N*K) difference
//               a - b - bin. It reuses one Full_Subtractor slice over K
//               cycles, starting with the least significant slice.
//
// Ports (sub_chain_ctrl):
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  begin an operation (sampled only in IDLE)
//   abort  in   1  cancel an operation in RUN
//   a      in   W  minuend
//   b      in   W  subtrahend
//   bin    in   1  initial borrow-in
//   busy   out  1  high while in RUN
//   done   out  1  one-cycle result-valid pulse
//   d      out  W  difference
//   bout   out  1  final borrow-out
//   ovf    out  1  signed overflow of the W-bit result
//
// Revision    : 1.0 - initial release
// ============================================================================

module Full_Subtractor #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);

  // The N+1-bit result keeps a borrow in its top bit. Because the true result
  // lies in [-2^N, 2^N-1], that bit is 1 exactly when a borrow occurred.
  logic [N:0] diff;

  assign diff = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
  assign d    = diff[N-1:0];
  assign bout = diff[N];

endmodule

module sub_chain_ctrl #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           bin,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] d,
  output logic           bout,
  output logic           ovf
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IW-1:0]  idx;
  logic           brw;

  logic [N-1:0]   sl_a;
  logic [N-1:0]   sl_b;
  logic [N-1:0]   sl_d;
  logic           sl_bout;
  logic           last;

  assign sl_a = a_q[idx*N +: N];
  assign sl_b = b_q[idx*N +: N];
  assign last = (idx == IW'(K - 1));

  Full_Subtractor #(
    .N (N)
  ) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bin  (brw),
    .d    (sl_d),
    .bout (sl_bout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Datapath: operand latch, slice index, borrow chain, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      idx  <= '0;
      brw  <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            brw  <= bin;
            idx  <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            idx  <= '0;
            brw  <= 1'b0;
          end else begin
            d[idx*N +: N] <= sl_d;
            brw           <= sl_bout;
            if (last) begin
              // The top bit of the new difference is the MSB of this slice.
              bout <= sl_bout;
              ovf  <= (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ sl_d[N-1]);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sub_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_chain_ctrl
// Description : Scoreboard testbench for sub_chain_ctrl (N=8, K=4).
//               The stimulus pushes the expected results. A monitor pops
//               and compares them on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_sub_chain_ctrl;

  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   n_cmp;
  int   n_err;
  int   done_seen;

  sub_chain_ctrl #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      res_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_d",    64'(d),    64'(e.d));
        chk("sb_bout", 64'(bout), 64'(e.bout));
        chk("sb_ovf",  64'(ovf),  64'(e.ovf));
      end
    end
  end

  // Counts cycles from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input logic with_abort);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; bin = tbin; start = 1'b1; abort = with_abort;
    exp_q.push_back({ed, eb, eo});
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("bout_cleared",     64'(bout), 64'd0);
    chk("ovf_cleared",      64'(ovf),  64'd0);
    wait_done(n);
    chk("latency", 64'(n), 64'd5);
    @(posedge clk); #1;
    chk("done_single", 64'(done), 64'd0);
    chk("hold_d",      64'(d),    64'(ed));
    chk("hold_bout",   64'(bout), 64'(eb));
    chk("hold_ovf",    64'(ovf),  64'(eo));
  endtask

  initial begin
    int n;
    int seen0;
    n_cmp = 0; n_err = 0; done_seen = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_d",    64'(d),    64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    chk("rst_ovf",  64'(ovf),  64'd0);
    rst = 1'b0;

    // abort in IDLE has no effect
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_idle_busy", 64'(busy), 64'd0);

    // Scenarios 1-4
    do_op(32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    do_op(32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    do_op(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    do_op(32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

    // start together with abort in IDLE: start wins
    do_op(32'h00000100, 32'h000000FF, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);

    // Scenario 5a: a second start while busy is ignored
    @(posedge clk); #1;
    a = 32'h00000010; b = 32'h00000020; bin = 1'b0; start = 1'b1;
    exp_q.push_back({32'hFFFFFFF0, 1'b1, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 32'h00000000; b = 32'h00000001; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s5_latency", 64'(n), 64'd5);
    repeat (6) @(posedge clk);
    #1;
    chk("s5_no_requeue_busy", 64'(busy), 64'd0);
    chk("s5_result_intact",   64'(d),    64'hFFFFFFF0);

    // Scenario 5b: abort in the second RUN cycle
    seen0 = done_seen;
    @(posedge clk); #1;
    a = 32'h00000005; b = 32'h00000003; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_d",    64'(d),    64'd0);
    chk("abort_bout", 64'(bout), 64'd0);
    chk("abort_ovf",  64'(ovf),  64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_seen), 64'(seen0));

    // Scenario 6: reset during RUN, then a fresh operation
    @(posedge clk); #1;
    a = 32'h00001234; b = 32'h00000034; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_done", 64'(done), 64'd0);
    chk("rstrun_d",    64'(d),    64'd0);
    chk("rstrun_bout", 64'(bout), 64'd0);
    chk("rstrun_ovf",  64'(ovf),  64'd0);
    do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("done_count", 64'(done_seen), 64'd7);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
